ram_rr_arbiter: RTL and testbench

Three-requester round-robin arbiter for the shared single-port synchronous RAM (10-bit word address, 32-bit data, 1-cycle registered read).
- Grants one requester per cycle and registers that requester's address, data and write-enable onto the RAM port.
- Supports back-to-back burst beats per grant, with a bounded burst length so no requester starves.
- Returns a per-port ack aligned with valid RAM read data.

---
 rtl/ram_rr_arbiter_if.sv | 18 +
 rtl/ram_rr_arbiter.sv | 72 +++++++
 tb/tb_ram_rr_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_rr_arbiter_if.sv
// ram_rr_arbiter_if: requester and RAM-side signals of the round-robin RAM arbiter
interface ram_rr_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [2:0]        req, we, grant, ack;
  logic [ADDR_W-1:0] addr0, addr1, addr2, ram_addr;
  logic [DATA_W-1:0] wdata0, wdata1, wdata2, rdata, ram_di, ram_do;
  logic              ram_en, ram_we, busy;
  modport slave (
    input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, ram_do,
    output grant, ack, rdata, ram_en, ram_we, ram_addr, ram_di, busy
  );
  modport master (
    output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, ram_do,
    input  grant, ack, rdata, ram_en, ram_we, ram_addr, ram_di, busy
  );
endinterface

// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: three-port round-robin arbiter with bounded bursts onto a single-port RAM
module ram_rr_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input logic             clk,
  input logic             reset,
  ram_rr_arbiter_if.slave bus
);
  logic              r_own_v, r_en, r_we, r_ack_v;
  logic [1:0]        r_own, r_last, r_iss_id, r_ack_id;
  logic [3:0]        r_cnt;
  logic [2:0]        r_grant, r_ack;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_di;
  logic              w_any, w_cont;
  logic [1:0]        w_p1, w_p2, w_sel, w_win;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  always_comb begin
    w_any   = |bus.req;
    // the owner keeps the RAM until its burst budget runs out and someone else is waiting
    w_cont  = r_own_v && bus.req[r_own] &&
              (r_cnt < 4'(MAX_BURST) || (bus.req & ~(3'b001 << r_own)) == 3'b000);
    w_p1    = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    w_p2    = (w_p1 == 2'd2) ? 2'd0 : w_p1 + 2'd1;
    w_sel   = bus.req[w_p1] ? w_p1 : bus.req[w_p2] ? w_p2 : r_last;
    w_win   = w_cont ? r_own : w_sel;
    w_addr  = (w_win == 2'd0) ? bus.addr0 : (w_win == 2'd1) ? bus.addr1 : bus.addr2;
    w_wdata = (w_win == 2'd0) ? bus.wdata0 : (w_win == 2'd1) ? bus.wdata1 : bus.wdata2;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_own_v  <= 1'b0;
      r_own    <= 2'd0;
      r_last   <= 2'd2;
      r_cnt    <= 4'd0;
      r_grant  <= 3'b000;
      r_en     <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_di     <= '0;
      r_iss_id <= 2'd0;
      r_ack_v  <= 1'b0;
      r_ack_id <= 2'd0;
      r_ack    <= 3'b000;
    end else begin
      r_own_v  <= w_any;
      r_own    <= w_win;
      r_last   <= w_any ? w_win : r_last;
      r_cnt    <= !w_any ? 4'd0 : (!w_cont || r_cnt == 4'(MAX_BURST)) ? 4'd1 : r_cnt + 4'd1;
      r_grant  <= w_any ? 3'b001 << w_win : 3'b000;
      r_en     <= w_any;
      r_we     <= w_any & bus.we[w_win];
      r_addr   <= w_any ? w_addr : '0;
      r_di     <= w_any ? w_wdata : '0;
      r_iss_id <= w_win;
      r_ack_v  <= r_en;
      r_ack_id <= r_iss_id;
      r_ack    <= r_ack_v ? 3'b001 << r_ack_id : 3'b000;
    end
  end
  assign bus.grant    = r_grant;
  assign bus.ack      = r_ack;
  assign bus.ram_en   = r_en;
  assign bus.ram_we   = r_we;
  assign bus.ram_addr = r_addr;
  assign bus.ram_di   = r_di;
  assign bus.rdata    = bus.ram_do;
  assign bus.busy     = r_en | r_ack_v;
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb_ram_rr_arbiter: random and directed traffic against a queue-based round-robin model and scoreboard
module tb_ram_rr_arbiter;
  localparam int MAXB = 4;
  typedef struct packed {logic w; logic [9:0] a; logic [31:0] d;} beat_t;
  logic clk, reset;
  ram_rr_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus();
  ram_rr_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(MAXB)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  beat_t rq[3][$];
  logic [32:0] sb[3][$];
  logic [31:0] ref_mem [int];
  int gap[3];
  bit rnd = 0;
  int owner = -1, run = 0, last = 2;
  logic [2:0] g_now = 0, g_m1 = 0, g_m2 = 0;
  function automatic logic [31:0] init_val(input logic [9:0] a);
    return 32'hA5A50000 ^ (32'(a) * 32'h00010001);
  endfunction
  // RAM: samples the issued beat at the edge after issue, read data appears one edge later
  logic [31:0] mem [1024];
  bit [1023:0] wr;
  logic [9:0] s_addr = 0;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      s_addr <= bus.ram_addr;
      if (bus.ram_we) begin
        mem[bus.ram_addr] <= bus.ram_di;
        wr[bus.ram_addr] <= 1'b1;
      end
    end
    bus.ram_do <= wr[s_addr] ? mem[s_addr] : init_val(s_addr);
  end
  function automatic logic [31:0] ref_rd(input logic [9:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction
  function automatic logic [9:0] base(input int p);
    return p == 0 ? 10'h000 : p == 1 ? 10'h3F0 : 10'h100;
  endfunction
  // round-robin rule: keep the owner while allowed, else first requester after the last winner
  function automatic logic [2:0] predict(input logic [2:0] r);
    int nxt = -1;
    if (owner >= 0 && r[owner] && (run < MAXB || (r & ~(3'b001 << owner)) == 3'b000)) nxt = owner;
    else for (int k = 1; k <= 3; k++) if (nxt < 0 && r[(last + k) % 3]) nxt = (last + k) % 3;
    if (nxt < 0) begin
      owner = -1;
      run = 0;
      return 3'b000;
    end
    run = (nxt == owner) ? run % MAXB + 1 : 1;
    owner = nxt;
    last = nxt;
    return 3'b001 << nxt;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic push(input int p, input logic w, input logic [9:0] a, input logic [31:0] d);
    rq[p].push_back(beat_t'({w, a, d}));
  endtask
  task automatic drive(input int p);
    beat_t b;
    bit on;
    on = rq[p].size() != 0 && gap[p] == 0;
    bus.req[p] = on;
    if (on) begin
      b = rq[p][0];
      bus.we[p] = b.w;
      if (p == 0) begin bus.addr0 = b.a; bus.wdata0 = b.d; end
      else if (p == 1) begin bus.addr1 = b.a; bus.wdata1 = b.d; end
      else begin bus.addr2 = b.a; bus.wdata2 = b.d; end
    end else bus.we[p] = 1'b0;
  endtask
  task automatic step(input bit rst_in);
    beat_t b;
    @(negedge clk);
    chk("grant", 32'(bus.grant), 32'(g_now));
    chk("ack_timing", 32'(bus.ack), 32'(g_m2));
    chk("ram_en", 32'(bus.ram_en), 32'(g_now != 3'b000));
    chk("busy", 32'(bus.busy), 32'(g_now != 3'b000 || g_m1 != 3'b000));
    for (int p = 0; p < 3; p++) if (bus.grant[p]) begin
      if (rq[p].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant_without_request port=%0d grant=%b", p, bus.grant);
      end else begin
        b = rq[p].pop_front();
        chk("ram_addr", 32'(bus.ram_addr), 32'(b.a));
        chk("ram_we", 32'(bus.ram_we), 32'(b.w));
        chk("ram_di", bus.ram_di, b.d);
        if (b.w) ref_mem[int'(b.a)] = b.d;
        sb[p].push_back(b.w ? 33'd0 : {1'b1, ref_rd(b.a)});
        gap[p] = rnd ? int'($urandom_range(0, 3)) : 0;
      end
    end
    reset = rst_in;
    for (int p = 0; p < 3; p++) begin
      if (gap[p] > 0) gap[p]--;
      drive(p);
    end
    if (rst_in) begin
      owner = -1; run = 0; last = 2;
      g_now = 0; g_m1 = 0; g_m2 = 0;
      for (int p = 0; p < 3; p++) sb[p].delete();
    end else begin
      g_m2 = g_m1;
      g_m1 = g_now;
      g_now = predict(bus.req);
    end
  endtask
  task automatic run_n(input int n);
    repeat (n) step(1'b0);
  endtask
  task automatic drained(input string nm);
    for (int p = 0; p < 3; p++) begin
      chk({nm, "_pending"}, 32'(rq[p].size()), 0);
      chk({nm, "_missing_ack"}, 32'(sb[p].size()), 0);
    end
  endtask
  // monitor: every ack must match the oldest outstanding beat of that port
  initial forever begin
    logic [32:0] e;
    int p;
    @(posedge clk);
    #1;
    if (bus.ack != 3'b000) begin
      chk("ack_onehot", 32'($countones(bus.ack)), 1);
      p = bus.ack[0] ? 0 : bus.ack[1] ? 1 : 2;
      if (sb[p].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack got=%b expected=none", bus.ack);
      end else begin
        e = sb[p].pop_front();
        if (e[32]) chk("rdata", bus.rdata, e[31:0]);
      end
    end
  end
  initial begin
    reset = 1'b1;
    bus.req = 0; bus.we = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.addr2 = 0;
    bus.wdata0 = 0; bus.wdata1 = 0; bus.wdata2 = 0;
    gap = '{0, 0, 0};
    repeat (3) step(1'b1);
    chk("rst_ram_addr", 32'(bus.ram_addr), 0);
    chk("rst_ram_di", bus.ram_di, 0);
    chk("rst_ram_we", 32'(bus.ram_we), 0);
    // single read beat
    push(0, 1'b0, 10'h010, 32'h0);
    run_n(6);
    drained("t1");
    // write then read back on port 1
    push(1, 1'b1, 10'h3FF, 32'hDEADBEEF);
    push(1, 1'b0, 10'h3FF, 32'h0);
    run_n(8);
    drained("t2");
    // all three ports saturating
    for (int i = 0; i < 16; i++)
      for (int p = 0; p < 3; p++) push(p, 1'($urandom_range(0, 1)), base(p) + 10'($urandom_range(0, 15)), $urandom);
    run_n(56);
    drained("t3");
    // lone requester never rotates away
    for (int i = 0; i < 10; i++) push(2, 1'b0, base(2) + 10'(i), 32'h0);
    run_n(16);
    drained("t4");
    // port 1 arrives exactly as port 0 drops
    push(0, 1'b0, 10'h020, 32'h0);
    push(0, 1'b1, 10'h021, 32'h12345678);
    push(1, 1'b0, 10'h3F5, 32'h0);
    gap[1] = 3;
    run_n(8);
    drained("t5");
    // reset one cycle after issue squashes the beat
    push(0, 1'b0, 10'h030, 32'h0);
    step(1'b0);
    push(1, 1'b0, 10'h3F1, 32'h0);
    push(2, 1'b0, 10'h101, 32'h0);
    step(1'b1);
    step(1'b1);
    run_n(10);
    drained("t6");
    rnd = 1;
    for (int c = 0; c < 2000; c++) begin
      for (int p = 0; p < 3; p++)
        if ($urandom_range(0, 3) == 0 && rq[p].size() < 4)
          push(p, 1'($urandom_range(0, 1)), base(p) + 10'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 499) == 0) begin
        step(1'b1);
        step(1'b1);
      end else step(1'b0);
    end
    rnd = 0;
    run_n(40);
    drained("rand");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
